seq_detect_param: RTL

SEQ_DETECT_PARAM -- requirements
Module: seq_detect_param

---
 rtl/seq_detect_param_if.sv | 24 ++
 rtl/seq_detect_param.sv | 67 ++++++
 2 files changed

// File: rtl/seq_detect_param_if.sv
// rtl/seq_detect_param_if.sv - serial pattern detector bus: bit stream, pattern load, match outputs
interface seq_detect_param_if #(
   parameter int PAT_LEN = 4,
   parameter int CNT_W   = 8
);
   logic               en;
   logic               w;
   logic               pat_load;
   logic [PAT_LEN-1:0] pat_in;
   logic               cnt_clr;
   logic               z;
   logic [CNT_W-1:0]   match_cnt;
   logic               cnt_sat;

   modport master (
      output en, w, pat_load, pat_in, cnt_clr,
      input  z, match_cnt, cnt_sat
   );

   modport slave (
      input  en, w, pat_load, pat_in, cnt_clr,
      output z, match_cnt, cnt_sat
   );
endinterface

// File: rtl/seq_detect_param.sv
// rtl/seq_detect_param.sv - loadable serial pattern detector with saturating match counter
module seq_detect_param #(
   parameter int                 PAT_LEN = 4,
   parameter logic [PAT_LEN-1:0] PATTERN = 4'b1101,
   parameter int                 OVERLAP = 1,
   parameter int                 CNT_W   = 8
) (
   input logic              clk,
   input logic              rst,
   seq_detect_param_if.slave bus
);
   localparam int FILL_W = $clog2(PAT_LEN + 1);
   localparam logic [FILL_W-1:0] FULL    = FILL_W'(PAT_LEN);
   localparam logic [CNT_W-1:0]  CNT_MAX = '1;

   logic [PAT_LEN-1:0] pat;
   logic [PAT_LEN-1:0] hist;
   logic [PAT_LEN-1:0] hist_n;
   logic [FILL_W-1:0]  fill;
   logic [FILL_W-1:0]  fill_n;
   logic               accept;
   logic               match;
   logic               z_q;
   logic [CNT_W-1:0]   cnt;

   // fill tracks how many valid bits hist holds, so a match needs a full window
   always_comb begin
      accept = bus.en && !bus.pat_load;
      hist_n = {hist[PAT_LEN-2:0], bus.w};
      fill_n = (fill == FULL) ? fill : fill + 1'b1;
      match  = accept && (fill_n == FULL) && (hist_n == pat);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pat  <= PATTERN;
         hist <= '0;
         fill <= '0;
         z_q  <= 1'b0;
         cnt  <= '0;
      end else begin
         z_q <= match;
         if (bus.pat_load) begin
            pat  <= bus.pat_in;
            hist <= '0;
            fill <= '0;
         end else if (bus.en) begin
            hist <= hist_n;
            fill <= (match && (OVERLAP == 0)) ? '0 : fill_n;
         end

         // a coincident clear still counts the match that lands on the same edge
         if (match) begin
            if (bus.cnt_clr)
               cnt <= CNT_W'(1);
            else if (cnt != CNT_MAX)
               cnt <= cnt + 1'b1;
         end else if (bus.cnt_clr) begin
            cnt <= '0;
         end
      end
   end

   assign bus.z         = z_q;
   assign bus.match_cnt = cnt;
   assign bus.cnt_sat   = (cnt == CNT_MAX);
endmodule
